// File: rtl/carry_step_modu_subtractor.sv
// carry_step_modu_subtractor: multi-cycle (a - b) mod 2^WIDTH, one carry-select block per clock
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (a minuend, b subtrahend)
//   out_valid, out_ready result handshake
//   diff                 (a - b) mod 2^WIDTH
//   borrow, zero, ovf    unsigned a < b, diff == 0, signed overflow
module carry_step_modu_subtractor #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int BW = NBLK > 1 ? $clog2(NBLK) : 1;
    localparam int MSB = WIDTH - 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, bn_q, bn_d, diff_q, diff_d;
    logic carry_q, carry_d, borrow_q, borrow_d, zero_q, zero_d, ovf_q, ovf_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [BLOCK:0] s0, s1, sel;
    logic accept, last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            bn_q     <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            blk_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            bn_q     <= bn_d;
            diff_q   <= diff_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            blk_q    <= blk_d;
        end
    end
    always_comb begin
        in_ready = state_q == IDLE || (state_q == DONE && out_ready);
        accept   = in_valid && in_ready;
        last     = blk_q == BW'(NBLK - 1);
        // both conditional block sums; the registered carry picks one
        s0       = {1'b0, a_q[blk_q*BLOCK +: BLOCK]} + {1'b0, bn_q[blk_q*BLOCK +: BLOCK]};
        s1       = s0 + (BLOCK + 1)'(1);
        sel      = carry_q ? s1 : s0;
        state_d  = state_q;
        a_d      = a_q;
        bn_d     = bn_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        blk_d    = blk_q;
        if (accept) begin
            // a + ~b + 1 is the two's-complement subtract
            a_d     = a;
            bn_d    = ~b;
            carry_d = 1'b1;
            blk_d   = '0;
            diff_d  = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            diff_d[blk_q*BLOCK +: BLOCK] = sel[BLOCK-1:0];
            carry_d = sel[BLOCK];
            blk_d   = last ? '0 : blk_q + BW'(1);
            if (last) begin
                state_d  = DONE;
                borrow_d = ~sel[BLOCK];
                zero_d   = diff_d == '0;
                // bn_q holds ~b, so equal MSBs here mean a and b differ in sign
                ovf_d    = (a_q[MSB] == bn_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    assign out_valid = state_q == DONE;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_carry_step_modu_subtractor.sv
// tb_carry_step_modu_subtractor: scoreboard bench with directed and random operands
module tb_carry_step_modu_subtractor;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, borrow, zero, ovf;
    logic [31:0] diff;
    typedef struct packed {logic [31:0] d; logic br; logic z; logic o;} res_t;
    res_t q[$];
    int   checks = 0, failures = 0;
    bit   rand_rdy = 1'b0;

    carry_step_modu_subtractor dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // signed overflow: the exact signed difference differs from its 32-bit wrap
    function automatic res_t model(logic [31:0] x, logic [31:0] y);
        res_t   r;
        longint sd;
        r.d  = x - y;
        r.br = x < y;
        r.z  = r.d == 32'd0;
        sd   = longint'($signed(x)) - longint'($signed(y));
        r.o  = sd != longint'($signed(r.d));
        return r;
    endfunction

    task automatic send(logic [31:0] x, logic [31:0] y, bit push);
        int n = 0;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) q.push_back(model(x, y));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("diff", diff, e.d);
                    chk("borrow", {31'd0, borrow}, {31'd0, e.br});
                    chk("zero", {31'd0, zero}, {31'd0, e.z});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
        end
    end

    initial begin
        int          c, n;
        logic [31:0] x, y;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", diff, 32'd0);
        chk("rst_flags", {29'd0, borrow, zero, ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'd5, 32'd3, 1'b1);
        wait_valid(c);
        chk("lat_basic", c, 32'd8);
        send(32'd3, 32'd5, 1'b1);
        wait_valid(c);
        send(32'd0, 32'd1, 1'b1);
        wait_valid(c);
        send(32'h8000_0000, 32'd1, 1'b1);
        wait_valid(c);
        send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        wait_valid(c);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h100, 32'h1, 1'b1);
        wait_valid(c);
        chk("lat_stall", c, 32'd8);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_diff", diff, 32'hFF);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h10, 32'h1, 1'b1);
        wait_valid(c);
        chk("lat_b2b", c, 32'd8);
        @(posedge clk);
        #1;
        send(32'h1234_5678, 32'd1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_diff", diff, 32'd0);
        chk("abort_flags", {29'd0, borrow, zero, ovf}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send(32'd7, 32'd7, 1'b1);
        wait_valid(c);
        chk("lat_after_rst", c, 32'd8);
        @(posedge clk);
        #1;
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = x;
                1: x = 32'h8000_0000;
                2: y = x + 32'd1;
                3: y = 32'h8000_0000;
                default: ;
            endcase
            send(x, y, 1'b1);
        end
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        rand_rdy = 1'b0;
        #1;
        out_ready = 1'b1;
        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
